screen_sequencer: RTL and testbench
===================================

# screen_sequencer

Top-level screen-flow controller for the VGA output path. Sequences the display between the start screen, the game board and the win/lose screens; commits every screen change on a frame boundary; and selects which renderer's pixel colour drives the output register. Sits between the VGA timing generator/renderers and the DAC pins. It also issues the one-cycle game-logic reset when a new game begins.

## Interface
- HOLD_FRAMES, 60: minimum frames WON/LOST are shown before a start press is accepted (1..255).
- FADE_STEP_FRAMES, 4: frames per fade step. Used only with SCREEN_FADE_EN (1..15).
- clk  input  1  pixel clock, 25 MHz.
- rst  input  1  asynchronous, active-low reset.
- active_pixels  input  1  visible-area flag from the timing generator.
- x  input  10  current pixel column.
- y  input  10  current pixel row.
- start_key_n  input  1  raw KEY3, active-low, asynchronous to clk.
- game_won  input  1  level from game logic.
- game_lost  input  1  level from game logic.
- start_color  input  24  start-screen renderer colour (RGB888).
- game_color  input  24  board renderer colour.
- over_color  input  24  win/lose renderer colour.
- color_out  output  24  registered pixel colour.
- screen_state  output  2  committed state: 0 START, 1 PLAY, 2 WON, 3 LOST.
- game_reset  output  1  one-cycle pulse when PLAY is entered.
- frame_tick  output  1  registered one-cycle pulse, one cycle after x==0 && y==0.

## Operation
- Key path: 2-flop synchronizer on start_key_n, then falling-edge detect, gives a one-cycle press pulse. A held key gives exactly one press.
- A frame start is x==0 && y==0, sampled combinationally.
- The next state is computed each cycle into a pending register. It is copied to screen_state only on a frame-start cycle.
- Transitions:
  - START + press → PLAY.
  - PLAY + game_lost → LOST.
  - PLAY + game_won → WON.
  - PLAY + game_won and game_lost together → LOST (lost has priority).
  - WON/LOST + press, with hold_cnt==HOLD_FRAMES → START.
- Presses are ignored in PLAY and during the WON/LOST hold. Ignored presses are not remembered.
- Once pending differs from screen_state, it is frozen until the next commit. Further events in that frame are ignored.
- hold_cnt (8-bit) clears on entry to WON/LOST. It increments on each committed frame start while in WON/LOST and saturates at HOLD_FRAMES.
- game_reset is asserted in the cycle after a commit into PLAY, for one cycle only.
- Colour select by screen_state: START → start_color, PLAY → game_color, WON/LOST → over_color.
- color_out is 24'h000000 when active_pixels is 0.

## Timing
- Reset values: screen_state=0 (START), pending=START, color_out=0, game_reset=0, frame_tick=0, hold_cnt=0, synchronizer flops=1, fade shift=0.
- Key latency: a press pulse occurs 3 clk edges after start_key_n falls (2 sync + edge register).
- Commit latency: screen_state changes on the frame-start edge after the cause. The worst case is one frame (420,000 cycles at 800×525).
- color_out has 1-cycle latency from x/y/active_pixels. The timing generator delays hsync/vsync by one cycle to match.
- Colour select uses the already-committed screen_state, so the whole frame after a commit is drawn from one source.
- Reset mid-frame returns to START immediately and asynchronously. The pending register is cleared.
- A press that arrives on the same cycle as a frame start commits in that same cycle.

## Configuration
- SCREEN_FADE_EN defined:
  - Each commit loads a 2-bit fade shift of 3.
  - The shift decrements every FADE_STEP_FRAMES committed frame starts, down to 0.
  - color_out per channel = selected channel >> shift.
  - A commit during a fade reloads 3.
- SCREEN_FADE_EN undefined: the shift is constant 0, there is no fade counter, and the colour switches immediately.

## Structure
- Package screen_pkg holds:
  - state encodings SCR_START/SCR_PLAY/SCR_WON/SCR_LOST (2-bit);
  - COLOR_BLACK = 24'h000000;
  - the frame-start coordinate constants.
- Sub-module key_sync_edge: parameterised synchronizer depth (2) plus falling-edge detector. Reset value is 1 (key released).
- The remaining FSM, counters and output mux are in screen_sequencer.

## Test plan
- Reset, then release rst mid-frame. Expect screen_state=0, color_out=0 while reset is asserted, then color_out=start_color one cycle after each active pixel.
- start_key_n held low for 1000 cycles in START. Expect one press, screen_state=1 at the next x=0,y=0 edge, game_reset high for exactly 1 cycle after it, and no second transition.
- In PLAY, assert game_won and game_lost on the same cycle. Expect screen_state=3 at the next frame start, and color_out=over_color for the following frame.
- In LOST, press at frame 10 after entry (HOLD_FRAMES=60). Expect it ignored. Press at frame 61. Expect START committed at the next frame start.
- Press arriving exactly on the x=0,y=0 cycle (after sync) in START. Expect commit on that edge and game_reset on the next cycle.
- SCREEN_FADE_EN with FADE_STEP_FRAMES=4, start_color=24'hF0F0F0. Expect 24'h1E1E1E for 4 frames, then 24'h3C3C3C, then 24'h787878, then 24'hF0F0F0.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared encodings and constants for the VGA screen-flow controller.
package screen_pkg;

    typedef enum logic [1:0] {
        SCR_START = 2'd0,
        SCR_PLAY  = 2'd1,
        SCR_WON   = 2'd2,
        SCR_LOST  = 2'd3
    } screen_t;

    localparam logic [23:0] COLOR_BLACK = 24'h000000;

    localparam logic [9:0] FRAME_X0 = 10'd0;
    localparam logic [9:0] FRAME_Y0 = 10'd0;

    // Per-channel right shift of an RGB888 colour.
    function automatic logic [23:0] dim_rgb(
        input logic [23:0] c,
        input logic [1:0]  s
    );
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = c[23:16] >> s;
        g = c[15:8] >> s;
        b = c[7:0] >> s;
        return {r, g, b};
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Synchronizer chain plus falling-edge detector for an active-low key.
// Released level (1) is the reset value so reset never yields a press.
module key_sync_edge
    import screen_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic [DEPTH-1:0] r_sync;
    logic             r_last;
    logic             r_press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '1;
            r_last  <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[DEPTH-2:0], i_key_n};
            r_last  <= r_sync[DEPTH-1];
            r_press <= r_last & ~r_sync[DEPTH-1];
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/screen_sequencer.sv
// Screen-flow FSM, frame-aligned commit and pixel colour select.
// Optional fade-in on each screen change: define SCREEN_FADE_EN.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int HOLD_FRAMES      = 60,
    parameter int FADE_STEP_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active_pixels,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        start_key_n,
    input  logic        game_won,
    input  logic        game_lost,
    input  logic [23:0] start_color,
    input  logic [23:0] game_color,
    input  logic [23:0] over_color,
    output logic [23:0] color_out,
    output logic [1:0]  screen_state,
    output logic        game_reset,
    output logic        frame_tick
);

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_FRAMES);

    screen_t     r_state;
    screen_t     r_pending;
    screen_t     w_next;
    logic [7:0]  r_hold;
    logic        r_game_reset;
    logic        r_frame_tick;
    logic [23:0] r_color;

    logic        w_press;
    logic        w_frame_start;
    logic        w_commit;
    logic        w_hold_done;
    logic        w_over;
    logic        w_next_over;
    logic [23:0] w_sel;
    logic [1:0]  w_shift;

    key_sync_edge #(
        .DEPTH (2)
    ) u_key (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_key_n (start_key_n),
        .o_press (w_press)
    );

    assign w_frame_start = (x == FRAME_X0) && (y == FRAME_Y0);
    assign w_hold_done   = (r_hold == HOLD_MAX);
    assign w_commit      = w_frame_start && (w_next != r_state);
    assign w_over        = (r_state == SCR_WON) || (r_state == SCR_LOST);
    assign w_next_over   = (w_next == SCR_WON) || (w_next == SCR_LOST);

    // A pending change is frozen until the frame-start commit.
    always_comb begin
        w_next = r_state;
        if (r_pending != r_state) begin
            w_next = r_pending;
        end else begin
            unique case (r_state)
                SCR_START: begin
                    if (w_press) w_next = SCR_PLAY;
                end
                SCR_PLAY: begin
                    if (game_lost)     w_next = SCR_LOST;
                    else if (game_won) w_next = SCR_WON;
                end
                SCR_WON, SCR_LOST: begin
                    if (w_press && w_hold_done) w_next = SCR_START;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= SCR_START;
            r_pending    <= SCR_START;
            r_hold       <= 8'd0;
            r_game_reset <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_pending    <= w_next;
            r_frame_tick <= w_frame_start;
            r_game_reset <= w_commit && (w_next == SCR_PLAY);
            if (w_frame_start) begin
                r_state <= w_next;
            end
            if (w_commit && w_next_over) begin
                r_hold <= 8'd0;
            end else if (w_frame_start && w_over && !w_hold_done) begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end

    always_comb begin
        w_sel = over_color;
        unique case (r_state)
            SCR_START: w_sel = start_color;
            SCR_PLAY:  w_sel = game_color;
            default:   w_sel = over_color;
        endcase
    end

`ifdef SCREEN_FADE_EN
    localparam logic [3:0] FADE_LAST = 4'(FADE_STEP_FRAMES - 1);

    logic [1:0] r_shift;
    logic [3:0] r_fade_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift    <= 2'd0;
            r_fade_cnt <= 4'd0;
        end else if (w_commit) begin
            r_shift    <= 2'd3;
            r_fade_cnt <= 4'd0;
        end else if (w_frame_start && (r_shift != 2'd0)) begin
            if (r_fade_cnt == FADE_LAST) begin
                r_shift    <= r_shift - 2'd1;
                r_fade_cnt <= 4'd0;
            end else begin
                r_fade_cnt <= r_fade_cnt + 4'd1;
            end
        end
    end

    assign w_shift = r_shift;
`else
    logic [3:0] w_unused_fade;

    assign w_unused_fade = 4'(FADE_STEP_FRAMES);
    assign w_shift       = 2'd0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_color <= COLOR_BLACK;
        end else if (active_pixels) begin
            r_color <= dim_rgb(w_sel, w_shift);
        end else begin
            r_color <= COLOR_BLACK;
        end
    end

    assign color_out    = r_color;
    assign screen_state = r_state;
    assign game_reset   = r_game_reset;
    assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer on a shrunken 8x4 raster.
module tb_screen_sequencer;

    localparam logic [9:0]  X_LAST  = 10'd7;
    localparam logic [9:0]  Y_LAST  = 10'd3;
    localparam logic [23:0] START_C = 24'hF0F0F0;
    localparam logic [23:0] GAME_C  = 24'h20A0E0;
    localparam logic [23:0] OVER_C  = 24'hC08040;
`ifdef SCREEN_FADE_EN
    localparam logic [23:0] OVER_F0 = 24'h181008;
`else
    localparam logic [23:0] OVER_F0 = OVER_C;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        active_pixels;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        start_key_n;
    logic        game_won;
    logic        game_lost;
    logic [23:0] color_out;
    logic [1:0]  screen_state;
    logic        game_reset;
    logic        frame_tick;

    int   n_err = 0;
    int   n_chk = 0;
    logic prev_act = 1'b0;
    logic prev_fs  = 1'b0;

    screen_sequencer #(
        .HOLD_FRAMES      (60),
        .FADE_STEP_FRAMES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .active_pixels (active_pixels),
        .x             (x),
        .y             (y),
        .start_key_n   (start_key_n),
        .game_won      (game_won),
        .game_lost     (game_lost),
        .start_color   (START_C),
        .game_color    (GAME_C),
        .over_color    (OVER_C),
        .color_out     (color_out),
        .screen_state  (screen_state),
        .game_reset    (game_reset),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        prev_act = active_pixels;
        prev_fs  = (x == 10'd0) && (y == 10'd0);
        #1;
        if (x == X_LAST) begin
            x = 10'd0;
            y = (y == Y_LAST) ? 10'd0 : y + 10'd1;
        end else begin
            x = x + 10'd1;
        end
        active_pixels = (x < 10'd6) && (y < 10'd3);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            tick();
            check("frame_tick", 32'(frame_tick), 32'(prev_fs));
            n++;
        end while (!prev_fs && n < 40);
        if (!prev_fs) check("fs_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [23:0] sel);
        for (int i = 0; i < 31; i++) begin
            tick();
            check(tag, 32'(color_out), 32'(prev_act ? sel : 24'h0));
        end
        wait_fs();
    endtask

    task automatic press();
        ticks(3);
        start_key_n = 1'b0;
        ticks(4);
        start_key_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int       nchg;
        int       ngr;
        int       chg_fs;
        int       chg_gr;
        logic [1:0]  last_st;
        logic [23:0] exp_c;

        rst           = 1'b0;
        x             = 10'd3;
        y             = 10'd1;
        active_pixels = 1'b1;
        start_key_n   = 1'b1;
        game_won      = 1'b0;
        game_lost     = 1'b0;

        ticks(3);
        check("rst_state", 32'(screen_state), 32'd0);
        check("rst_color", 32'(color_out), 32'd0);
        check("rst_greset", 32'(game_reset), 32'd0);
        check("rst_ftick", 32'(frame_tick), 32'd0);
        rst = 1'b1;
        check_frame("start_color", START_C);
        check("start_state", 32'(screen_state), 32'd0);

        // Held key: exactly one press and one commit.
        ticks(5);
        start_key_n = 1'b0;
        nchg    = 0;
        ngr     = 0;
        chg_fs  = 0;
        chg_gr  = 0;
        last_st = screen_state;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (screen_state != last_st) begin
                nchg++;
                chg_fs = int'(prev_fs);
                chg_gr = int'(game_reset);
            end
            if (game_reset) ngr++;
            last_st = screen_state;
        end
        start_key_n = 1'b1;
        check("hold_changes", nchg, 1);
        check("hold_at_fs", chg_fs, 1);
        check("hold_greset_at", chg_gr, 1);
        check("hold_greset_cnt", ngr, 1);
        check("hold_state", 32'(screen_state), 32'd1);
        wait_fs();
        check_frame("play_color", GAME_C);

        press();
        wait_fs();
        wait_fs();
        check("play_press_ign", 32'(screen_state), 32'd1);

        // Simultaneous won + lost: lost wins.
        ticks(3);
        game_won  = 1'b1;
        game_lost = 1'b1;
        tick();
        game_won  = 1'b0;
        game_lost = 1'b0;
        check("pre_commit", 32'(screen_state), 32'd1);
        wait_fs();
        check("lost_commit", 32'(screen_state), 32'd3);
        check_frame("over_color", OVER_F0);

        repeat (9) wait_fs();
        press();
        wait_fs();
        check("lost_f10_ign", 32'(screen_state), 32'd3);
        repeat (48) wait_fs();
        press();
        wait_fs();
        check("lost_f59_ign", 32'(screen_state), 32'd3);
        press();
        check("lost_pending", 32'(screen_state), 32'd3);
        wait_fs();
        check("lost_to_start", 32'(screen_state), 32'd0);

        for (int f = 0; f < 13; f++) begin
`ifdef SCREEN_FADE_EN
            exp_c = (f < 4)  ? 24'h1E1E1E :
                    (f < 8)  ? 24'h3C3C3C :
                    (f < 12) ? 24'h787878 : START_C;
`else
            exp_c = START_C;
`endif
            check_frame("fade_color", exp_c);
        end

        // Press lands on the frame-start cycle itself.
        ticks(28);
        start_key_n = 1'b0;
        ticks(3);
        check("fs_press_pre", 32'(screen_state), 32'd0);
        tick();
        check("fs_press_edge", 32'(prev_fs), 32'd1);
        check("fs_press_state", 32'(screen_state), 32'd1);
        check("fs_press_greset", 32'(game_reset), 32'd1);
        tick();
        check("fs_greset_once", 32'(game_reset), 32'd0);
        start_key_n = 1'b1;

        // Won first, then lost in the same frame: pending stays WON.
        wait_fs();
        ticks(3);
        game_won = 1'b1;
        tick();
        game_won  = 1'b0;
        game_lost = 1'b1;
        tick();
        game_lost = 1'b0;
        wait_fs();
        check("won_frozen", 32'(screen_state), 32'd2);
        check("won_no_greset", 32'(game_reset), 32'd0);
        press();
        wait_fs();
        check("won_hold_ign", 32'(screen_state), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
